// File: rtl/pred_unit_pipe.sv
// -----------------------------------------------------------------------------
// pred_unit_pipe
//   Pipelined multi-lane intra prediction unit.
//   Per lane:
//     angular : (w1*r1 + w2*r2 + 16) >> 5
//     planar  : (w1*r1 + w2*r2 + ((r1a+r2a+1) << L)) >> (L+1),  L = min(pu,4)+2
//   All products are built by shift-add.
//   Three register stages:
//     S1 - input capture
//     S2 - products and rounding/corner term
//     S3 - sum, shift, narrow, plus block framing
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   input handshake
//   in_first              beat opens a new PU block
//   pu                    block size code (0=4x4 .. >=4 -> 64x64)
//   angle_or_planar       1 = angular, 0 = planar
//   weight1 / weight2     per-lane weights, lane 0 in the LSBs
//   ref1 / ref2           per-lane main references
//   ref1a / ref2a         per-lane planar corner references
//   out_valid / out_ready output handshake
//   pred_out              per-lane predicted samples
//   out_last              final beat of a block, qualified by out_valid
//
// Build option
//   PRED_CLIP_EN  defined   : each lane saturates to 2^BIT_DEPTH-1
//                 undefined : each lane wraps to its low BIT_DEPTH bits
// -----------------------------------------------------------------------------
module pred_unit_pipe #(
    parameter int BIT_DEPTH = 8,
    parameter int LANES     = 4,
    parameter int WEIGHT_W  = 7
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_first,
    input  logic [2:0]                    pu,
    input  logic                          angle_or_planar,
    input  logic [LANES*WEIGHT_W-1:0]     weight1,
    input  logic [LANES*WEIGHT_W-1:0]     weight2,
    input  logic [LANES*BIT_DEPTH-1:0]    ref1,
    input  logic [LANES*BIT_DEPTH-1:0]    ref2,
    input  logic [LANES*BIT_DEPTH-1:0]    ref1a,
    input  logic [LANES*BIT_DEPTH-1:0]    ref2a,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*BIT_DEPTH-1:0]    pred_out,
    output logic                          out_last
);

    localparam int S  = BIT_DEPTH + WEIGHT_W + 3;
    localparam int LG = $clog2(LANES);

    // Unsigned product via one gated, shifted copy of r per weight bit.
    function automatic logic [S-1:0] shift_add_mul(input logic [WEIGHT_W-1:0] w,
                                                   input logic [BIT_DEPTH-1:0] r);
        logic [S-1:0] acc;
        logic [S-1:0] r_ext;
        acc   = {S{1'b0}};
        r_ext = S'(r);
        for (int b = 0; b < WEIGHT_W; b++) begin
            if (w[b]) acc = acc + (r_ext << b);
            else      acc = acc;
        end
        return acc;
    endfunction

    // Block size code to log2 of the PU edge length.
    function automatic logic [2:0] pu_to_l(input logic [2:0] p);
        if (p >= 3'd4) return 3'd6;
        else           return p + 3'd2;
    endfunction

    // Narrow the shifted sum to the sample width.
    function automatic logic [BIT_DEPTH-1:0] narrow(input logic [S-1:0] v);
`ifdef PRED_CLIP_EN
        if (|v[S-1:BIT_DEPTH]) return {BIT_DEPTH{1'b1}};
        else                   return v[BIT_DEPTH-1:0];
`else
        return v[BIT_DEPTH-1:0];
`endif
    endfunction

    // ---------------- stage registers ----------------
    logic                         s1_v_r, s1_first_r, s1_ang_r;
    logic [2:0]                   s1_pu_r;
    logic [LANES*WEIGHT_W-1:0]    s1_w1_r, s1_w2_r;
    logic [LANES*BIT_DEPTH-1:0]   s1_r1_r, s1_r2_r, s1_r1a_r, s1_r2a_r;

    logic                         s2_v_r, s2_first_r;
    logic [2:0]                   s2_pu_r, s2_sh_r;
    logic [S-1:0]                 s2_p1_r [LANES];
    logic [S-1:0]                 s2_p2_r [LANES];
    logic [S-1:0]                 s2_t_r  [LANES];

    logic                         out_valid_r, out_last_r;
    logic [LANES*BIT_DEPTH-1:0]   pred_r;
    logic [11:0]                  cnt_r, blen_r;
    logic                         busy_r;

    // ---------------- combinational signals ----------------
    logic                         in_ready_s;
    logic [2:0]                   s1_l_s, sh_nx_s;
    logic [S-1:0]                 p1_nx_s [LANES];
    logic [S-1:0]                 p2_nx_s [LANES];
    logic [S-1:0]                 t_nx_s  [LANES];
    logic [LANES*BIT_DEPTH-1:0]   pred_nx_s;
    logic [3:0]                   blen_exp_s;
    logic [11:0]                  blen_beat_s, idx_s, blen_use_s, cnt_nx_s, blen_nx_s;
    logic                         busy_nx_s, last_nx_s;

    // Whole pipe advances together; it only stops when the output is held.
    assign in_ready_s = ~rst & ~(out_valid_r & ~out_ready);
    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign out_last   = out_last_r;
    assign pred_out   = pred_r;

    // S2 datapath: products, rounding or corner term, and final shift amount.
    always_comb begin
        s1_l_s = pu_to_l(s1_pu_r);
        if (s1_ang_r) sh_nx_s = 3'd5;
        else          sh_nx_s = s1_l_s + 3'd1;
        for (int i = 0; i < LANES; i++) begin
            p1_nx_s[i] = shift_add_mul(s1_w1_r[i*WEIGHT_W +: WEIGHT_W], s1_r1_r[i*BIT_DEPTH +: BIT_DEPTH]);
            p2_nx_s[i] = shift_add_mul(s1_w2_r[i*WEIGHT_W +: WEIGHT_W], s1_r2_r[i*BIT_DEPTH +: BIT_DEPTH]);
            if (s1_ang_r) begin
                t_nx_s[i] = S'(5'd16);
            end else begin
                t_nx_s[i] = (S'(s1_r1a_r[i*BIT_DEPTH +: BIT_DEPTH]) +
                             S'(s1_r2a_r[i*BIT_DEPTH +: BIT_DEPTH]) + S'(1'b1)) << s1_l_s;
            end
        end
    end

    // S3 datapath: sum, shift and narrow each lane.
    always_comb begin
        pred_nx_s = {(LANES*BIT_DEPTH){1'b0}};
        for (int i = 0; i < LANES; i++) begin
            pred_nx_s[i*BIT_DEPTH +: BIT_DEPTH] =
                narrow((s2_p1_r[i] + s2_p2_r[i] + s2_t_r[i]) >> s2_sh_r);
        end
    end

    // Block framing, evaluated as each beat enters the output register.
    // Beats in the output register always transfer before the next one
    // loads, so counting at load time equals counting transfers.
    // blen is B-1; with B = 4096 the 12-bit shift wraps to 0 and the
    // subtraction yields 4095 as required.
    always_comb begin
        blen_exp_s  = {pu_to_l(s2_pu_r), 1'b0} - 4'(LG);
        blen_beat_s = (12'd1 << blen_exp_s) - 12'd1;
        cnt_nx_s    = cnt_r;
        busy_nx_s   = busy_r;
        blen_nx_s   = blen_r;
        last_nx_s   = out_last_r;
        idx_s       = 12'd0;
        blen_use_s  = blen_r;
        if (in_ready_s) begin
            if (s2_v_r) begin
                if (s2_first_r || !busy_r) begin
                    idx_s      = 12'd0;
                    blen_use_s = blen_beat_s;
                end else begin
                    idx_s      = cnt_r;
                    blen_use_s = blen_r;
                end
                blen_nx_s = blen_use_s;
                last_nx_s = (idx_s == blen_use_s);
                if (idx_s == blen_use_s) begin
                    cnt_nx_s  = 12'd0;
                    busy_nx_s = 1'b0;
                end else begin
                    cnt_nx_s  = idx_s + 12'd1;
                    busy_nx_s = 1'b1;
                end
            end else begin
                last_nx_s = 1'b0;
            end
        end else begin
            last_nx_s = out_last_r;
        end
    end

    // S1: capture the input beat and its control.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_r     <= 1'b0;
            s1_first_r <= 1'b0;
            s1_ang_r   <= 1'b0;
            s1_pu_r    <= 3'd0;
            s1_w1_r    <= {(LANES*WEIGHT_W){1'b0}};
            s1_w2_r    <= {(LANES*WEIGHT_W){1'b0}};
            s1_r1_r    <= {(LANES*BIT_DEPTH){1'b0}};
            s1_r2_r    <= {(LANES*BIT_DEPTH){1'b0}};
            s1_r1a_r   <= {(LANES*BIT_DEPTH){1'b0}};
            s1_r2a_r   <= {(LANES*BIT_DEPTH){1'b0}};
        end else if (in_ready_s) begin
            s1_v_r     <= in_valid;
            s1_first_r <= in_first;
            s1_ang_r   <= angle_or_planar;
            s1_pu_r    <= pu;
            s1_w1_r    <= weight1;
            s1_w2_r    <= weight2;
            s1_r1_r    <= ref1;
            s1_r2_r    <= ref2;
            s1_r1a_r   <= ref1a;
            s1_r2a_r   <= ref2a;
        end
    end

    // S2: register products, term and the control that travels with them.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v_r     <= 1'b0;
            s2_first_r <= 1'b0;
            s2_pu_r    <= 3'd0;
            s2_sh_r    <= 3'd0;
            for (int i = 0; i < LANES; i++) begin
                s2_p1_r[i] <= {S{1'b0}};
                s2_p2_r[i] <= {S{1'b0}};
                s2_t_r[i]  <= {S{1'b0}};
            end
        end else if (in_ready_s) begin
            s2_v_r     <= s1_v_r;
            s2_first_r <= s1_first_r;
            s2_pu_r    <= s1_pu_r;
            s2_sh_r    <= sh_nx_s;
            for (int i = 0; i < LANES; i++) begin
                s2_p1_r[i] <= p1_nx_s[i];
                s2_p2_r[i] <= p2_nx_s[i];
                s2_t_r[i]  <= t_nx_s[i];
            end
        end
    end

    // S3: output register and block counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            pred_r      <= {(LANES*BIT_DEPTH){1'b0}};
            cnt_r       <= 12'd0;
            blen_r      <= 12'd0;
            busy_r      <= 1'b0;
        end else begin
            if (in_ready_s) begin
                out_valid_r <= s2_v_r;
                pred_r      <= pred_nx_s;
            end
            out_last_r <= last_nx_s;
            cnt_r      <= cnt_nx_s;
            blen_r     <= blen_nx_s;
            busy_r     <= busy_nx_s;
        end
    end

endmodule

// File: tb/tb_pred_unit_pipe.sv
module tb_pred_unit_pipe;

    localparam int BD    = 8;
    localparam int LANES = 4;
    localparam int WW    = 7;
    localparam longint MAXV = (64'd1 << BD) - 64'd1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst, in_valid, in_ready, in_first, angle_or_planar;
    logic [2:0]               pu;
    logic [LANES*WW-1:0]      weight1, weight2;
    logic [LANES*BD-1:0]      ref1, ref2, ref1a, ref2a, pred_out;
    logic                     out_valid, out_ready, out_last;

    pred_unit_pipe #(.BIT_DEPTH(BD), .LANES(LANES), .WEIGHT_W(WW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
        .pu(pu), .angle_or_planar(angle_or_planar),
        .weight1(weight1), .weight2(weight2),
        .ref1(ref1), .ref2(ref2), .ref1a(ref1a), .ref2a(ref2a),
        .out_valid(out_valid), .out_ready(out_ready),
        .pred_out(pred_out), .out_last(out_last)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [LANES*BD-1:0] pred;
        logic                last;
    } exp_t;

    exp_t exp_q[$];
    int   m_cnt  = 0;
    bit   m_busy = 1'b0;
    int   m_blen = 0;
    int   last_seen = 0;

    task automatic model_accept();
        exp_t   e;
        int     l, b, idx;
        longint w1, w2, r1, r2, ra, rb, v;
        l = (pu >= 3'd4) ? 6 : int'(pu) + 2;
        for (int i = 0; i < LANES; i++) begin
            w1 = longint'(weight1[i*WW +: WW]);
            w2 = longint'(weight2[i*WW +: WW]);
            r1 = longint'(ref1[i*BD +: BD]);
            r2 = longint'(ref2[i*BD +: BD]);
            ra = longint'(ref1a[i*BD +: BD]);
            rb = longint'(ref2a[i*BD +: BD]);
            if (angle_or_planar) v = (w1*r1 + w2*r2 + 16) / 32;
            else                 v = (w1*r1 + w2*r2 + (ra + rb + 1) * (64'd1 << l)) / (64'd1 << (l + 1));
`ifdef PRED_CLIP_EN
            if (v > MAXV) v = MAXV;
`else
            v = v % (MAXV + 1);
`endif
            e.pred[i*BD +: BD] = BD'(v);
        end
        b = (1 << (2 * l)) / LANES;
        if (in_first || !m_busy) begin
            idx    = 0;
            m_blen = b;
        end else begin
            idx = m_cnt;
        end
        e.last = (idx == m_blen - 1);
        if (e.last) begin
            m_busy = 1'b0;
            m_cnt  = 0;
        end else begin
            m_busy = 1'b1;
            m_cnt  = idx + 1;
        end
        exp_q.push_back(e);
    endtask

    // ---------------- monitor (samples on the falling edge) ----------------
    bit                  stall_prev = 1'b0;
    logic [LANES*BD-1:0] held_pred;
    logic                held_last;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
            m_busy     = 1'b0;
            m_cnt      = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check_eq("hold_valid", out_valid, 1'b1);
                check_eq("hold_pred", pred_out, held_pred);
                check_eq("hold_last", out_last, held_last);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_beat", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("pred", pred_out, e.pred);
                    check_eq("last", out_last, e.last);
                    if (out_last) last_seen++;
                end
            end
            stall_prev = out_valid && !out_ready;
            if (stall_prev) begin
                held_pred = pred_out;
                held_last = out_last;
                check_eq("stall_in_ready", in_ready, 1'b0);
            end
            if (in_valid && in_ready) model_accept();
        end
    end

    // ---------------- downstream ready driver ----------------
    bit rand_ready  = 1'b0;
    bit force_ready = 1'b1;

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 9) < 7);
            else            out_ready = force_ready;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_uniform(input bit first, input logic [2:0] p, input bit ang,
                               input int w1, input int w2, input int r1, input int r2,
                               input int ra, input int rb);
        in_first        = first;
        pu              = p;
        angle_or_planar = ang;
        for (int i = 0; i < LANES; i++) begin
            weight1[i*WW +: WW] = WW'(w1);
            weight2[i*WW +: WW] = WW'(w2);
            ref1[i*BD +: BD]    = BD'(r1);
            ref2[i*BD +: BD]    = BD'(r2);
            ref1a[i*BD +: BD]   = BD'(ra);
            ref2a[i*BD +: BD]   = BD'(rb);
        end
    endtask

    task automatic set_random(input bit first, input logic [2:0] p);
        in_first        = first;
        pu              = p;
        angle_or_planar = 1'($urandom_range(0, 1));
        for (int i = 0; i < LANES; i++) begin
            weight1[i*WW +: WW] = WW'($urandom);
            weight2[i*WW +: WW] = WW'($urandom);
            ref1[i*BD +: BD]    = BD'($urandom);
            ref2[i*BD +: BD]    = BD'($urandom);
            ref1a[i*BD +: BD]   = BD'($urandom);
            ref2a[i*BD +: BD]   = BD'($urandom);
        end
    endtask

    // Present the beat already set up and hold it until it is accepted.
    task automatic push_beat();
        int t = 0;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 200) begin
                check_eq("accept_timeout", 1'b1, 1'b0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Send a single beat into an empty pipe and check result and latency.
    task automatic send_check(input string tag, input logic [2:0] p, input bit ang,
                              input int w1, input int w2, input int r1, input int r2,
                              input int ra, input int rb, input logic [LANES*BD-1:0] exp);
        int cyc = 0;
        set_uniform(1'b0, p, ang, w1, w2, r1, r2, ra, rb);
        push_beat();
        forever begin
            @(negedge clk);
            cyc++;
            if (out_valid || cyc > 20) break;
        end
        check_eq({tag, "_latency"}, 64'(cyc), 64'd3);
        check_eq(tag, pred_out, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        rand_ready  = 1'b0;
        force_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    int ls0;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        set_uniform(1'b0, 3'd0, 1'b0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("reset_out_valid", out_valid, 1'b0);
        check_eq("reset_pred", pred_out, 0);
        check_eq("reset_last", out_last, 1'b0);
        check_eq("idle_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Directed arithmetic vectors.
        send_check("angular", 3'd0, 1'b1, 26, 6, 100, 200, 0, 0, {LANES{8'd119}});
        send_check("planar_pu0", 3'd0, 1'b0, 3, 1, 100, 60, 80, 40, {LANES{8'd105}});
        send_check("planar_pu1", 3'd1, 1'b0, 3, 1, 100, 60, 80, 40, {LANES{8'd83}});
`ifdef PRED_CLIP_EN
        send_check("overflow", 3'd0, 1'b0, 4, 4, 255, 255, 255, 255, {LANES{8'd255}});
`else
        send_check("overflow", 3'd0, 1'b0, 4, 4, 255, 255, 255, 255, {LANES{8'd254}});
`endif
        drain();

        // Framing: pu=0 block of 4 beats.
        ls0 = last_seen;
        for (int k = 0; k < 4; k++) begin
            set_random(k == 0, 3'd0);
            push_beat();
        end
        drain();
        check_eq("frame_pu0_lasts", 64'(last_seen - ls0), 64'd1);

        // Framing: pu=1 block of 16 beats.
        ls0 = last_seen;
        for (int k = 0; k < 16; k++) begin
            set_random(k == 0, 3'd1);
            push_beat();
        end
        drain();
        check_eq("frame_pu1_lasts", 64'(last_seen - ls0), 64'd1);

        // Framing: restart at beat 2, then 4 beats of the new block.
        ls0 = last_seen;
        for (int k = 0; k < 6; k++) begin
            set_random(k == 0 || k == 2, 3'd0);
            push_beat();
        end
        drain();
        check_eq("frame_restart_lasts", 64'(last_seen - ls0), 64'd1);

        // Backpressure: 10 beats with a 5-cycle downstream stall.
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    set_uniform(k == 0, 3'd1, k[0], k + 1, 2 * k + 3, 10 * k + 5, 200 - 7 * k, k, 3 * k);
                    push_beat();
                end
            end
            begin
                repeat (4) @(posedge clk);
                force_ready = 1'b0;
                repeat (5) @(posedge clk);
                force_ready = 1'b1;
            end
        join
        drain();
        check_eq("backpressure_drained", 64'(exp_q.size()), 64'd0);

        // Reset with three beats in flight.
        for (int k = 0; k < 3; k++) begin
            set_random(k == 0, 3'd0);
            push_beat();
        end
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_out_valid", out_valid, 1'b0);
        check_eq("midrst_pred", pred_out, 0);
        repeat (6) @(posedge clk);
        #1;
        ls0 = last_seen;
        for (int k = 0; k < 4; k++) begin
            set_random(1'b0, 3'd0);
            push_beat();
        end
        drain();
        check_eq("post_rst_lasts", 64'(last_seen - ls0), 64'd1);

        // Randomized stream with random downstream readiness.
        rand_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            logic [2:0] p;
            if ($urandom_range(0, 3) == 0) p = 3'($urandom_range(0, 7));
            else                           p = 3'($urandom_range(0, 1));
            set_random($urandom_range(0, 7) == 0, p);
            push_beat();
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        drain();
        check_eq("random_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time bound for the whole run.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1);
    end

endmodule
